// File: rtl/char_render_scheduler.sv
// Scans the text buffer row-major and hands each cell needing redraw (dirty, forced or cursor)
// to the glyph renderer together with its bitmap and framebuffer word address.
module char_render_scheduler #(
  parameter int COLUMNS  = 80,
  parameter int ROWS     = 30,
  parameter int CHAR_W   = 8,
  parameter int CHAR_H   = 16,
  parameter int ADDR_W   = 20,
  parameter int TEXT_LAT = 1,
  parameter int FONT_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       force_all,
  input  logic [ADDR_W-1:0]          frame_base,
  input  logic                       cursor_en,
  input  logic [4:0]                 cursor_row,
  input  logic [6:0]                 cursor_col,
  output logic [11:0]                text_addr,
  input  logic [31:0]                text_data,
  output logic                       dirty_clr,
  output logic [7:0]                 font_addr,
  input  logic [CHAR_W*CHAR_H-1:0]   font_data,
  output logic [CHAR_W*CHAR_H-1:0]   grid_shape,
  output logic [8:0]                 grid_fg,
  output logic [8:0]                 grid_bg,
  output logic [3:0]                 grid_effect,
  output logic                       grid_cursor,
  output logic [ADDR_W-1:0]          base_addr,
  output logic                       font_ready,
  input  logic                       render_done,
  output logic                       busy,
  output logic                       frame_done,
  output logic [3:0]                 dbgState
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] TEXT_RD   = 4'd1;
  localparam logic [3:0] CHECK     = 4'd2;
  localparam logic [3:0] FONT_RD   = 4'd3;
  localparam logic [3:0] DISPATCH  = 4'd4;
  localparam logic [3:0] WAIT_ACK  = 4'd5;
  localparam logic [3:0] WAIT_DONE = 4'd6;
  localparam logic [3:0] CLEAR     = 4'd7;
  localparam logic [3:0] NEXT      = 4'd8;
  localparam logic [3:0] FIN       = 4'd9;

  localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(CHAR_W / 2);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(CHAR_H * COLUMNS * CHAR_W / 2);

  logic [3:0]               state;
  logic [3:0]               latCnt;
  logic [4:0]               row;
  logic [6:0]               col;
  logic [11:0]              textBase;
  logic [ADDR_W-1:0]        rowBase;
  logic [ADDR_W-1:0]        colOff;
  logic [ADDR_W-1:0]        frameBase;
  logic                     forceLat;
  logic [30:0]              cellData;
  logic [CHAR_W*CHAR_H-1:0] glyph;
  logic                     cursorHit;
  logic                     cursorHere;
  logic                     lastCol;
  logic                     lastCell;

  assign cursorHere = cursor_en && (row == cursor_row) && (col == cursor_col);
  assign lastCol    = (col == 7'(COLUMNS - 1));
  assign lastCell   = lastCol && (row == 5'(ROWS - 1));

  assign text_addr  = textBase + 12'(col);
  assign font_addr  = cellData[7:0];
  assign dirty_clr  = (state == CLEAR);
  assign frame_done = (state == FIN);
  assign busy       = (state != IDLE) && (state != FIN);
  assign dbgState   = state;

  // Handshake: font_ready is a one-cycle valid pulse raised only after render_done was seen high
  // (renderer idle); render_done falling is the acceptance, and its return high marks completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      latCnt      <= '0;
      row         <= '0;
      col         <= '0;
      textBase    <= '0;
      rowBase     <= '0;
      colOff      <= '0;
      frameBase   <= '0;
      forceLat    <= 1'b0;
      cellData    <= '0;
      glyph       <= '0;
      cursorHit   <= 1'b0;
      grid_shape  <= '0;
      grid_fg     <= '0;
      grid_bg     <= '0;
      grid_effect <= '0;
      grid_cursor <= 1'b0;
      base_addr   <= '0;
      font_ready  <= 1'b0;
    end else begin
      font_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            forceLat  <= force_all;
            frameBase <= frame_base;
            row       <= '0;
            col       <= '0;
            textBase  <= '0;
            rowBase   <= '0;
            colOff    <= '0;
            latCnt    <= '0;
            state     <= TEXT_RD;
          end
        end
        TEXT_RD: begin
          if (latCnt == 4'(TEXT_LAT)) begin
            cellData <= text_data[30:0];
            latCnt   <= '0;
            state    <= CHECK;
          end else begin
            latCnt <= latCnt + 4'd1;
          end
        end
        CHECK: begin
          cursorHit <= cursorHere;
          state     <= (cellData[30] || forceLat || cursorHere) ? FONT_RD : NEXT;
        end
        FONT_RD: begin
          if (latCnt == 4'(FONT_LAT)) begin
            glyph  <= font_data;
            latCnt <= '0;
            state  <= DISPATCH;
          end else begin
            latCnt <= latCnt + 4'd1;
          end
        end
        DISPATCH: begin
          if (render_done) begin
            grid_shape  <= glyph;
            grid_fg     <= cellData[16:8];
            grid_bg     <= cellData[25:17];
            grid_effect <= cellData[29:26];
            grid_cursor <= cursorHit;
            base_addr   <= frameBase + rowBase + colOff;
            font_ready  <= 1'b1;
            state       <= WAIT_ACK;
          end
        end
        WAIT_ACK:  if (!render_done) state <= WAIT_DONE;
        WAIT_DONE: if (render_done) state <= CLEAR;
        CLEAR:     state <= NEXT;
        NEXT: begin
          latCnt <= '0;
          if (lastCell) begin
            row      <= '0;
            col      <= '0;
            textBase <= '0;
            rowBase  <= '0;
            colOff   <= '0;
            state    <= FIN;
          end else begin
            if (!lastCol) begin
              col    <= col + 7'd1;
              colOff <= colOff + COL_STEP;
            end else begin
              col      <= '0;
              colOff   <= '0;
              row      <= row + 5'd1;
              rowBase  <= rowBase + ROW_STEP;
              textBase <= textBase + 12'(COLUMNS);
            end
            state <= TEXT_RD;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_char_render_scheduler.sv
// Bench for char_render_scheduler: text RAM / font ROM / renderer models around the DUT,
// with a dispatch scoreboard filled from a shadow copy of the text buffer.
module tb_char_render_scheduler;

  localparam int EXP_W = 171;
  localparam int NCELL = 2400;

  logic         clk;
  logic         rst;
  logic         start;
  logic         force_all;
  logic [19:0]  frame_base;
  logic         cursor_en;
  logic [4:0]   cursor_row;
  logic [6:0]   cursor_col;
  logic [11:0]  text_addr;
  logic [31:0]  text_data;
  logic         dirty_clr;
  logic [7:0]   font_addr;
  logic [127:0] font_data;
  logic [127:0] grid_shape;
  logic [8:0]   grid_fg;
  logic [8:0]   grid_bg;
  logic [3:0]   grid_effect;
  logic         grid_cursor;
  logic [19:0]  base_addr;
  logic         font_ready;
  logic         render_done;
  logic         busy;
  logic         frame_done;
  logic [3:0]   dbg_state;

  char_render_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .force_all(force_all), .frame_base(frame_base),
    .cursor_en(cursor_en), .cursor_row(cursor_row), .cursor_col(cursor_col),
    .text_addr(text_addr), .text_data(text_data), .dirty_clr(dirty_clr),
    .font_addr(font_addr), .font_data(font_data), .grid_shape(grid_shape),
    .grid_fg(grid_fg), .grid_bg(grid_bg), .grid_effect(grid_effect),
    .grid_cursor(grid_cursor), .base_addr(base_addr), .font_ready(font_ready),
    .render_done(render_done), .busy(busy), .frame_done(frame_done), .dbgState(dbg_state)
  );

  int checks = 0;
  int failures = 0;
  int disp_count = 0;
  int clr_count = 0;
  int frame_count = 0;
  int hold_cycles = 2;

  logic [EXP_W-1:0] exp_q[$];
  logic [11:0]      clr_q[$];
  logic [19:0]      obs_base[$];
  logic [31:0]      shadow[NCELL];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [127:0] glyph(input logic [7:0] code);
    logic [127:0] g;
    for (int i = 0; i < 16; i++) g[i*8 +: 8] = code ^ 8'(i * 37);
    return g;
  endfunction

  function automatic logic [31:0] make_cell(input bit dirty, input logic [3:0] eff,
                                            input logic [8:0] bg, input logic [8:0] fg,
                                            input logic [7:0] code);
    return {1'b0, dirty, eff, bg, fg, code};
  endfunction

  // text RAM (1-cycle read) and font ROM (2-cycle read) models
  logic [31:0]  text_mem[NCELL];
  logic [31:0]  text_q;
  logic [127:0] font_p0, font_p1;
  logic         cfg_we, cfg_clr;
  logic [11:0]  cfg_addr;
  logic [31:0]  cfg_data;

  always @(posedge clk) begin
    if (cfg_clr) begin
      for (int i = 0; i < NCELL; i++) text_mem[i] <= '0;
    end else if (cfg_we) begin
      text_mem[cfg_addr] <= cfg_data;
    end else if (dirty_clr) begin
      text_mem[text_addr] <= text_mem[text_addr] & ~32'h4000_0000;
    end
    text_q  <= text_mem[text_addr];
    font_p0 <= glyph(font_addr);
    font_p1 <= font_p0;
  end
  assign text_data = text_q;
  assign font_data = font_p1;

  // renderer model: accepts a pulse while idle, drops render_done, stays busy hold_cycles
  initial begin
    render_done = 1'b1;
    forever begin
      @(negedge clk);
      if (font_ready === 1'b1 && render_done === 1'b1) begin
        @(negedge clk);
        render_done = 1'b0;
        repeat (hold_cycles) @(negedge clk);
        render_done = 1'b1;
      end
    end
  end

  // scoreboard monitor
  initial begin
    logic [EXP_W-1:0] exp_v;
    logic [EXP_W-1:0] obs_v;
    logic [11:0]      exp_a;
    forever begin
      @(negedge clk);
      if (font_ready === 1'b1) begin
        disp_count++;
        obs_base.push_back(base_addr);
        checks++;
        if (render_done !== 1'b1) begin
          failures++;
          $display("FAIL ready_while_busy render_done=%b required=1", render_done);
        end
        checks++;
        obs_v = {grid_cursor, grid_effect, grid_bg, grid_fg, base_addr, grid_shape};
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_dispatch got=%h required=none", obs_v);
        end else begin
          exp_v = exp_q.pop_front();
          if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL dispatch got=%h required=%h", obs_v, exp_v);
          end
        end
      end
      if (dirty_clr === 1'b1) begin
        clr_count++;
        checks++;
        if (clr_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_clear addr=%0d required=none", text_addr);
        end else begin
          exp_a = clr_q.pop_front();
          if (text_addr !== exp_a) begin
            failures++;
            $display("FAIL clear_addr got=%0d required=%0d", text_addr, exp_a);
          end
        end
      end
      if (frame_done === 1'b1) begin
        frame_count++;
        checks++;
        if (clr_q.size() != 0) begin
          failures++;
          $display("FAIL frame_before_clear pending=%0d required=0", clr_q.size());
        end
      end
    end
  end

  // driver tasks
  task automatic clear_text();
    for (int i = 0; i < NCELL; i++) shadow[i] = '0;
    @(negedge clk);
    cfg_clr = 1'b1;
    @(negedge clk);
    cfg_clr = 1'b0;
  endtask

  task automatic set_cell(input int r, input int c, input logic [31:0] d);
    shadow[r*80+c] = d;
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = 12'(r*80+c);
    cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic build_expect(input bit frc, input logic [19:0] fb, input bit c_en,
                              input int cr, input int cc, input bit commit);
    logic [31:0] d;
    logic [19:0] b;
    bit          hit;
    for (int r = 0; r < 30; r++) begin
      for (int c = 0; c < 80; c++) begin
        d   = shadow[r*80+c];
        hit = c_en && (r == cr) && (c == cc);
        if (d[30] || frc || hit) begin
          b = fb + 20'(r * 5120) + 20'(c * 4);
          exp_q.push_back({hit, d[29:26], d[25:17], d[16:8], b, glyph(d[7:0])});
          clr_q.push_back(12'(r*80+c));
          if (commit) shadow[r*80+c][30] = 1'b0;
        end
      end
    end
  endtask

  task automatic pulse_start(input bit frc, input logic [19:0] fb);
    @(negedge clk);
    force_all  = frc;
    frame_base = fb;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    force_all  = ~frc;
    frame_base = 20'($urandom_range(0, 20'hFFFFF));
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_after_start got=%b required=1", busy);
    end
  endtask

  task automatic wait_frame(input int budget);
    int n = 0;
    while (frame_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame_done !== 1'b1) begin
      failures++;
      $display("FAIL frame_timeout waited=%0d required=frame_done", n);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_after_frame got=%b required=0", busy);
    end
  endtask

  task automatic wait_renderer_idle();
    int n = 0;
    while (render_done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (render_done !== 1'b1) begin
      failures++;
      $display("FAIL renderer_idle_timeout got=%b required=1", render_done);
    end
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, frame_done, font_ready, dirty_clr} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b required=0000", {busy, frame_done, font_ready, dirty_clr});
    end
    checks++;
    if ({text_addr, font_addr, base_addr, grid_fg, grid_bg, grid_effect, grid_cursor} !== '0 ||
        grid_shape !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h required=0", {text_addr, font_addr, base_addr}, grid_shape);
    end
    checks++;
    if (dbg_state !== 4'd0) begin
      failures++;
      $display("FAIL reset_state got=%0d required=0", dbg_state);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_cell();
    int d0, c0, f0;
    clear_text();
    set_cell(0, 0, make_cell(1'b1, 4'b0001, 9'h155, 9'h0AA, 8'h41));
    set_cell(0, 1, make_cell(1'b0, 4'b0000, 9'h001, 9'h002, 8'h42));
    obs_base.delete();
    d0 = disp_count; c0 = clr_count; f0 = frame_count;
    build_expect(1'b0, 20'h0, 1'b0, 0, 0, 1'b1);
    pulse_start(1'b0, 20'h0);
    wait_frame(12000);
    checks++;
    if (disp_count - d0 != 1 || clr_count - c0 != 1 || frame_count - f0 != 1) begin
      failures++;
      $display("FAIL single_counts disp=%0d clr=%0d frame=%0d required=1/1/1",
               disp_count - d0, clr_count - c0, frame_count - f0);
    end
    checks++;
    if (obs_base.size() != 1 || obs_base[0] !== 20'h0) begin
      failures++;
      $display("FAIL single_base n=%0d required=1 base=0", obs_base.size());
    end
  endtask

  task automatic test_attr_cursor();
    int d0, c0;
    clear_text();
    set_cell(2, 3, make_cell(1'b1, 4'b1010, 9'h04B, 9'h1A5, 8'h5A));
    set_cell(5, 10, make_cell(1'b0, 4'b0101, 9'h10F, 9'h0F0, 8'h33));
    set_cell(7, 7, make_cell(1'b0, 4'b1111, 9'h1FF, 9'h1FF, 8'h77));
    cursor_en = 1'b1; cursor_row = 5'd5; cursor_col = 7'd10;
    obs_base.delete();
    d0 = disp_count; c0 = clr_count;
    build_expect(1'b0, 20'h00100, 1'b1, 5, 10, 1'b1);
    pulse_start(1'b0, 20'h00100);
    wait_frame(12000);
    checks++;
    if (disp_count - d0 != 2 || clr_count - c0 != 2) begin
      failures++;
      $display("FAIL attr_counts disp=%0d clr=%0d required=2/2", disp_count - d0, clr_count - c0);
    end
    checks++;
    if (obs_base.size() < 1 || obs_base[0] !== 20'h0290C) begin
      failures++;
      $display("FAIL attr_base got=%h required=0290c", obs_base.size() ? obs_base[0] : 20'h0);
    end
    checks++;
    if ({grid_cursor, grid_fg, grid_bg, grid_effect} !== {1'b1, 9'h0F0, 9'h10F, 4'b0101}) begin
      failures++;
      $display("FAIL cursor_cell_held got=%h required=%h", {grid_cursor, grid_fg, grid_bg, grid_effect},
               {1'b1, 9'h0F0, 9'h10F, 4'b0101});
    end
    cursor_en = 1'b0;
  endtask

  task automatic test_force_all();
    int d0, f0;
    clear_text();
    hold_cycles = 1;
    obs_base.delete();
    d0 = disp_count; f0 = frame_count;
    build_expect(1'b1, 20'h0, 1'b0, 0, 0, 1'b1);
    pulse_start(1'b1, 20'h0);
    wait_frame(40000);
    checks++;
    if (disp_count - d0 != 2400 || frame_count - f0 != 1) begin
      failures++;
      $display("FAIL force_counts disp=%0d frame=%0d required=2400/1", disp_count - d0, frame_count - f0);
    end
    checks++;
    if (obs_base.size() != 2400 || obs_base[obs_base.size()-1] !== 20'h2453C) begin
      failures++;
      $display("FAIL force_last_base n=%0d required=2400 last=2453c", obs_base.size());
    end
    hold_cycles = 2;
  endtask

  task automatic test_stall();
    logic [170:0] snap;
    int n, extra;
    bit stable;
    clear_text();
    set_cell(0, 1, make_cell(1'b1, 4'b0110, 9'h0C3, 9'h13C, 8'h99));
    set_cell(0, 2, make_cell(1'b1, 4'b1001, 9'h011, 9'h022, 8'h12));
    hold_cycles = 200;
    build_expect(1'b0, 20'h03000, 1'b0, 0, 0, 1'b0);
    pulse_start(1'b0, 20'h03000);
    n = 0;
    while (font_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (font_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_first_dispatch waited=%0d required=font_ready", n);
    end
    snap = {grid_cursor, grid_effect, grid_bg, grid_fg, base_addr, grid_shape};
    extra = 0;
    stable = 1'b1;
    repeat (190) begin
      @(negedge clk);
      if (font_ready === 1'b1) extra++;
      if ({grid_cursor, grid_effect, grid_bg, grid_fg, base_addr, grid_shape} !== snap) stable = 1'b0;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL stall_second_ready got=%0d required=0", extra);
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("FAIL stall_grid_stable got=changed required=stable");
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    clr_q.delete();
    wait_renderer_idle();
    hold_cycles = 2;
  endtask

  task automatic test_reset_mid_pass();
    int n, c0, d0;
    clear_text();
    set_cell(0, 0, make_cell(1'b1, 4'b0011, 9'h0F1, 9'h1E2, 8'h21));
    set_cell(0, 5, make_cell(1'b1, 4'b1100, 9'h0AB, 9'h0CD, 8'h7E));
    hold_cycles = 20;
    build_expect(1'b0, 20'h0, 1'b0, 0, 0, 1'b0);
    c0 = clr_count;
    pulse_start(1'b0, 20'h0);
    n = 0;
    while (dbg_state !== 4'd6 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (dbg_state !== 4'd6) begin
      failures++;
      $display("FAIL reach_wait_done waited=%0d state=%0d required=6", n, dbg_state);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, font_ready, dirty_clr, frame_done} !== 4'b0000 || dbg_state !== 4'd0) begin
      failures++;
      $display("FAIL rst_mid_ctrl got=%b state=%0d required=0000/0",
               {busy, font_ready, dirty_clr, frame_done}, dbg_state);
    end
    checks++;
    if (base_addr !== 20'h0 || grid_shape !== '0 || text_addr !== 12'h0) begin
      failures++;
      $display("FAIL rst_mid_data base=%h addr=%0d required=0", base_addr, text_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (clr_count != c0) begin
      failures++;
      $display("FAIL rst_mid_clear got=%0d required=0", clr_count - c0);
    end
    exp_q.delete();
    clr_q.delete();
    wait_renderer_idle();
    hold_cycles = 2;
    obs_base.delete();
    d0 = disp_count;
    build_expect(1'b0, 20'h0, 1'b0, 0, 0, 1'b1);
    pulse_start(1'b0, 20'h0);
    checks++;
    if (text_addr !== 12'h0 || dbg_state !== 4'd1) begin
      failures++;
      $display("FAIL rescan_origin addr=%0d state=%0d required=0/1", text_addr, dbg_state);
    end
    wait_frame(12000);
    checks++;
    if (disp_count - d0 != 2 || obs_base.size() < 1 || obs_base[0] !== 20'h0) begin
      failures++;
      $display("FAIL rescan_dispatch n=%0d required=2 first_base=0", disp_count - d0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; force_all = 1'b0; frame_base = '0;
    cursor_en = 1'b0; cursor_row = '0; cursor_col = '0;
    cfg_we = 1'b0; cfg_clr = 1'b0; cfg_addr = '0; cfg_data = '0;
    test_reset();
    test_single_cell();
    test_attr_cursor();
    test_force_all();
    test_stall();
    test_reset_mid_pass();
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
